// File: rtl/sd_block_arbiter_if.sv
// Requester-side and sd_controller-side signals of sd_block_arbiter.
// master = the arbiter's view; slave = the requesters and controller.
interface sd_block_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [63:0] req_addr;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [15:0] req_din;
    logic [1:0]  req_din_valid;
    logic [1:0]  req_din_taken;
    logic [15:0] req_dout;
    logic [1:0]  req_dout_avail;
    logic [1:0]  req_dout_taken;
    logic [1:0]  grant;
    logic        sd_rd;
    logic        sd_wr;
    logic [31:0] sd_addr;
    logic        sd_busy;
    logic        sd_error;
    logic [7:0]  sd_din;
    logic        sd_din_valid;
    logic        sd_din_taken;
    logic [7:0]  sd_dout;
    logic        sd_dout_avail;
    logic        sd_dout_taken;

    modport master (
        input  req_valid, req_wr, req_addr, req_din, req_din_valid, req_dout_taken,
               sd_busy, sd_error, sd_din_taken, sd_dout, sd_dout_avail,
        output req_ack, req_done, req_err, req_din_taken, req_dout, req_dout_avail,
               grant, sd_rd, sd_wr, sd_addr, sd_din, sd_din_valid, sd_dout_taken
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_din, req_din_valid, req_dout_taken,
               sd_busy, sd_error, sd_din_taken, sd_dout, sd_dout_avail,
        input  req_ack, req_done, req_err, req_din_taken, req_dout, req_dout_avail,
               grant, sd_rd, sd_wr, sd_addr, sd_din, sd_din_valid, sd_dout_taken
    );
endinterface

// File: rtl/sd_block_arbiter.sv
// Two-requester block arbiter in front of sd_controller; one whole block per grant.
// States: IDLE arbitrate | START issue sd_rd/sd_wr | XFER route bytes | FINISH wait !sd_busy, report
module sd_block_arbiter #(
    parameter int          BLOCK_SIZE = 512,
    parameter logic [23:0] TIMEOUT    = 24'hFFFFFF,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input logic                clk,
    input logic                rst,
    sd_block_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BLOCK_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, START, XFER, FINISH} state_t;
    state_t state, state_nxt;

    logic             owner, rr_last, wr_q, err_flag, avail_d, taken_d;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] count;
    logic [23:0]      tmo;
    logic             winner, hs_edge, byte_evt, timed_out, abort, grant_en, done_en;

    // Round-robin tie goes to whoever was not served last; otherwise the sole requester wins.
    always_comb begin
        if (FIXED_PRIO || bus.req_valid != 2'b11) winner = !bus.req_valid[0];
        else                                      winner = !rr_last;
    end

    assign hs_edge   = (bus.sd_dout_avail != avail_d) || (bus.sd_din_taken != taken_d);
    assign byte_evt  = (state == XFER) &&
                       (wr_q ? (bus.sd_din_taken && !taken_d) : (avail_d && !bus.sd_dout_avail));
    assign timed_out = (TIMEOUT != 24'd0) && (state == XFER) && (tmo == 24'd0) && !hs_edge;
    assign abort     = ((state == START) || (state == XFER)) && (bus.sd_error || timed_out);
    assign grant_en  = (state == IDLE) && (bus.req_valid != 2'b00) && !bus.sd_busy;
    assign done_en   = (state == FINISH) && !bus.sd_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_en) state_nxt = START;
            START:   state_nxt = abort ? FINISH : XFER;
            XFER:    if (abort || (byte_evt && count == LAST_BYTE)) state_nxt = FINISH;
            FINISH:  if (!bus.sd_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'b0;
            rr_last  <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            count    <= '0;
            err_flag <= 1'b0;
            tmo      <= '0;
            avail_d  <= 1'b0;
            taken_d  <= 1'b0;
        end else begin
            avail_d <= bus.sd_dout_avail;
            taken_d <= bus.sd_din_taken;
            if (grant_en) begin
                owner  <= winner;
                wr_q   <= bus.req_wr[winner];
                addr_q <= winner ? bus.req_addr[63:32] : bus.req_addr[31:0];
            end
            // Inactivity timer reloads on every controller-side handshake edge.
            if (state == START || (state == XFER && hs_edge)) tmo <= TIMEOUT - 24'd1;
            else if (state == XFER && tmo != 24'd0)           tmo <= tmo - 24'd1;
            if (byte_evt) count <= count + 1'b1;
            if (abort) err_flag <= 1'b1;
            if (done_en) begin
                count    <= '0;
                err_flag <= 1'b0;
                rr_last  <= owner;
            end
        end
    end

    always_comb begin
        bus.req_ack        = '0;
        bus.req_done       = '0;
        bus.req_err        = '0;
        bus.grant          = '0;
        bus.req_din_taken  = '0;
        bus.req_dout       = '0;
        bus.req_dout_avail = '0;
        bus.sd_rd          = 1'b0;
        bus.sd_wr          = 1'b0;
        bus.sd_din         = '0;
        bus.sd_din_valid   = 1'b0;
        bus.sd_dout_taken  = 1'b0;
        bus.sd_addr        = addr_q;
        if (grant_en) bus.req_ack[winner] = 1'b1;
        if (state != IDLE) bus.grant[owner] = 1'b1;
        if (state == START || state == XFER) begin
            bus.sd_rd = !wr_q;
            bus.sd_wr = wr_q;
        end
        if (state == XFER) begin
            bus.sd_din                = owner ? bus.req_din[15:8] : bus.req_din[7:0];
            bus.sd_din_valid          = bus.req_din_valid[owner];
            bus.sd_dout_taken         = bus.req_dout_taken[owner];
            bus.req_din_taken[owner]  = bus.sd_din_taken;
            bus.req_dout_avail[owner] = bus.sd_dout_avail;
            if (owner) bus.req_dout[15:8] = bus.sd_dout;
            else       bus.req_dout[7:0]  = bus.sd_dout;
        end
        if (done_en) begin
            bus.req_done[owner] = 1'b1;
            bus.req_err[owner]  = err_flag;
        end
    end
endmodule
